// File: rtl/rob_tagged_regfile.sv
// rob_tagged_regfile
//   Architectural register file with per-register rename state (busy bit plus ROB tag).
//   It sits between decode/dispatch and ROB commit. Register 0 is hardwired to zero.
//
// Ports
//   clk          in   clock; all state updates on the rising edge
//   rst          in   synchronous, active-high reset (data, tags and busy cleared)
//   i_disp_we    in   dispatch renames i_disp_rd to i_disp_tag
//   i_disp_rd    in   destination register of the dispatched instruction
//   i_disp_tag   in   ROB tag allocated to the dispatched instruction
//   i_cmt_we     in   per-port commit valid (higher index = younger)
//   i_cmt_rd     in   per-port committed destination register
//   i_cmt_tag    in   per-port ROB tag of the committing entry
//   i_cmt_data   in   per-port committed result
//   i_flush      in   mispredict/exception recovery; drops all rename state
//   i_rd_idx     in   per-read-port source register index
//   o_rd_val     out  per-read-port data when ready, else owning ROB tag zero-extended
//   o_rd_ready   out  per-read-port: 1 = o_rd_val is architectural data
module rob_tagged_regfile #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NCMT   = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned RW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_disp_we,
  input  logic [RW-1:0]         i_disp_rd,
  input  logic [ROB_W-1:0]      i_disp_tag,
  input  logic [NCMT-1:0]       i_cmt_we,
  input  logic [NCMT*RW-1:0]    i_cmt_rd,
  input  logic [NCMT*ROB_W-1:0] i_cmt_tag,
  input  logic [NCMT*XLEN-1:0]  i_cmt_data,
  input  logic                  i_flush,
  input  logic [NRD*RW-1:0]     i_rd_idx,
  output logic [NRD*XLEN-1:0]   o_rd_val,
  output logic [NRD-1:0]        o_rd_ready
);

  logic [XLEN-1:0]  r_data [NREGS];
  logic [ROB_W-1:0] r_tag  [NREGS];
  logic [NREGS-1:0] r_busy;

  logic [XLEN-1:0]  w_data_d [NREGS];
  logic [ROB_W-1:0] w_tag_d  [NREGS];
  logic [NREGS-1:0] w_busy_d;
  logic [NREGS-1:0] w_clr;

  // Next-state: commits first (ascending port order so the youngest port's data wins),
  // then flush, then dispatch so a same-cycle rename keeps the register busy.
  always_comb begin
    logic [RW-1:0] rd;
    w_data_d = r_data;
    w_tag_d  = r_tag;
    w_busy_d = r_busy;
    w_clr    = '0;
    rd       = '0;
    for (int k = 0; k < int'(NCMT); k++) begin
      rd = i_cmt_rd[k*RW +: RW];
      if (i_cmt_we[k] && (rd != '0)) begin
        w_data_d[rd] = i_cmt_data[k*XLEN +: XLEN];
        // Tag mismatch means a younger writer is still in flight.
        if (r_tag[rd] == i_cmt_tag[k*ROB_W +: ROB_W]) begin
          w_clr[rd] = 1'b1;
        end
      end
    end
    w_busy_d = w_busy_d & ~w_clr;
    if (i_flush) begin
      w_busy_d = '0;
    end else if (i_disp_we && (i_disp_rd != '0)) begin
      w_tag_d[i_disp_rd]  = i_disp_tag;
      w_busy_d[i_disp_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_busy <= '0;
    end else begin
      r_data <= w_data_d;
      r_tag  <= w_tag_d;
      r_busy <= w_busy_d;
    end
  end

  // Combinational reads of pre-edge state, with optional same-cycle commit forwarding.
  always_comb begin
    logic [RW-1:0] idx;
    logic          hit;
    o_rd_val   = '0;
    o_rd_ready = '0;
    idx        = '0;
    hit        = 1'b0;
    for (int p = 0; p < int'(NRD); p++) begin
      idx = i_rd_idx[p*RW +: RW];
      if (idx == '0) begin
        o_rd_val[p*XLEN +: XLEN] = '0;
        o_rd_ready[p]            = 1'b1;
      end else begin
        if (r_busy[idx]) begin
          o_rd_val[p*XLEN +: XLEN] = XLEN'(r_tag[idx]);
          o_rd_ready[p]            = 1'b0;
        end else begin
          o_rd_val[p*XLEN +: XLEN] = r_data[idx];
          o_rd_ready[p]            = 1'b1;
        end
        if (BYPASS != 0) begin
          for (int k = 0; k < int'(NCMT); k++) begin
            // A busy register only forwards from the commit that owns its current tag.
            hit = i_cmt_we[k] && (i_cmt_rd[k*RW +: RW] == idx) &&
                  (!r_busy[idx] || (i_cmt_tag[k*ROB_W +: ROB_W] == r_tag[idx]));
            if (hit) begin
              o_rd_val[p*XLEN +: XLEN] = i_cmt_data[k*XLEN +: XLEN];
              o_rd_ready[p]            = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_tagged_regfile.sv
// Self-checking bench for rob_tagged_regfile: directed scenarios followed by randomized
// traffic, all compared against a behavioural register-file model.
module tb_rob_tagged_regfile;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned ROB_W  = 4;
  localparam int unsigned NRD    = 2;
  localparam int unsigned NCMT   = 2;
  localparam int unsigned BYPASS = 1;
  localparam int unsigned RW     = $clog2(NREGS);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_disp_we;
  logic [RW-1:0]         i_disp_rd;
  logic [ROB_W-1:0]      i_disp_tag;
  logic [NCMT-1:0]       i_cmt_we;
  logic [NCMT*RW-1:0]    i_cmt_rd;
  logic [NCMT*ROB_W-1:0] i_cmt_tag;
  logic [NCMT*XLEN-1:0]  i_cmt_data;
  logic                  i_flush;
  logic [NRD*RW-1:0]     i_rd_idx;
  logic [NRD*XLEN-1:0]   o_rd_val;
  logic [NRD-1:0]        o_rd_ready;

  rob_tagged_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .ROB_W (ROB_W),
    .NRD   (NRD),
    .NCMT  (NCMT),
    .BYPASS(BYPASS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_disp_we (i_disp_we),
    .i_disp_rd (i_disp_rd),
    .i_disp_tag(i_disp_tag),
    .i_cmt_we  (i_cmt_we),
    .i_cmt_rd  (i_cmt_rd),
    .i_cmt_tag (i_cmt_tag),
    .i_cmt_data(i_cmt_data),
    .i_flush   (i_flush),
    .i_rd_idx  (i_rd_idx),
    .o_rd_val  (o_rd_val),
    .o_rd_ready(o_rd_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural value, owning tag and rename-pending flag per register.
  logic [XLEN-1:0]  m_data [NREGS];
  logic [ROB_W-1:0] m_tag  [NREGS];
  bit               m_busy [NREGS];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    i_disp_we  = 1'b0;
    i_disp_rd  = '0;
    i_disp_tag = '0;
    i_cmt_we   = '0;
    i_cmt_rd   = '0;
    i_cmt_tag  = '0;
    i_cmt_data = '0;
    i_flush    = 1'b0;
    i_rd_idx   = '0;
  endtask

  task automatic set_disp(input int rd, input int tag);
    i_disp_we  = 1'b1;
    i_disp_rd  = RW'(rd);
    i_disp_tag = ROB_W'(tag);
  endtask

  task automatic set_cmt(input int k, input int rd, input int tag, input logic [XLEN-1:0] d);
    i_cmt_we[k]                = 1'b1;
    i_cmt_rd[k*RW +: RW]       = RW'(rd);
    i_cmt_tag[k*ROB_W +: ROB_W] = ROB_W'(tag);
    i_cmt_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input int idx);
    i_rd_idx[p*RW +: RW] = RW'(idx);
  endtask

  // Expected read: the architectural view seen by a consumer in this cycle.
  function automatic void model_read(input int idx, output logic [XLEN-1:0] v, output logic r);
    v = m_data[idx];
    r = 1'b1;
    if (idx == 0) begin
      v = '0;
      return;
    end
    if (m_busy[idx]) begin
      v = XLEN'(m_tag[idx]);
      r = 1'b0;
    end
    if (BYPASS != 0) begin
      for (int k = 0; k < int'(NCMT); k++) begin
        if (i_cmt_we[k] && (int'(i_cmt_rd[k*RW +: RW]) == idx) &&
            (!m_busy[idx] || (i_cmt_tag[k*ROB_W +: ROB_W] == m_tag[idx]))) begin
          v = i_cmt_data[k*XLEN +: XLEN];
          r = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_update();
    bit clr [NREGS];
    int rd;
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        m_data[i] = '0;
        m_tag[i]  = '0;
        m_busy[i] = 1'b0;
      end
      return;
    end
    for (int i = 0; i < int'(NREGS); i++) clr[i] = 1'b0;
    for (int k = 0; k < int'(NCMT); k++) begin
      rd = int'(i_cmt_rd[k*RW +: RW]);
      if (i_cmt_we[k] && rd != 0) begin
        m_data[rd] = i_cmt_data[k*XLEN +: XLEN];
        if (m_tag[rd] == i_cmt_tag[k*ROB_W +: ROB_W]) clr[rd] = 1'b1;
      end
    end
    for (int i = 0; i < int'(NREGS); i++) begin
      if (clr[i] || i_flush) m_busy[i] = 1'b0;
    end
    if (i_disp_we && i_disp_rd != '0 && !i_flush) begin
      m_tag[i_disp_rd]  = i_disp_tag;
      m_busy[i_disp_rd] = 1'b1;
    end
  endfunction

  task automatic chk_reads();
    logic [XLEN-1:0] ev;
    logic            er;
    #1;
    for (int p = 0; p < int'(NRD); p++) begin
      model_read(int'(i_rd_idx[p*RW +: RW]), ev, er);
      check_eq($sformatf("rd_val[%0d] x%0d", p, i_rd_idx[p*RW +: RW]),
               64'(o_rd_val[p*XLEN +: XLEN]), 64'(ev));
      check_eq($sformatf("rd_ready[%0d] x%0d", p, i_rd_idx[p*RW +: RW]),
               64'(o_rd_ready[p]), 64'(er));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk_port0(input string tag, input logic [XLEN-1:0] v, input logic r);
    check_eq({tag, "_val"}, 64'(o_rd_val[XLEN-1:0]), 64'(v));
    check_eq({tag, "_rdy"}, 64'(o_rd_ready[0]), 64'(r));
  endtask

  initial begin
    int rd;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // Post-reset reads of x5 and x0.
    set_rd(0, 5); set_rd(1, 0);
    chk_reads();
    chk_port0("reset_x5", '0, 1'b1);
    check_eq("reset_x0_val", 64'(o_rd_val[2*XLEN-1:XLEN]), 64'd0);
    tick();

    // Dispatch x3 tag 7, then commit it with bypass.
    clear_inputs(); set_disp(3, 7); set_rd(0, 3);
    chk_reads();
    chk_port0("disp_same_cycle_old_map", '0, 1'b1);
    tick();
    clear_inputs(); set_rd(0, 3);
    chk_reads();
    chk_port0("x3_busy_tag", 32'd7, 1'b0);
    tick();
    clear_inputs(); set_cmt(0, 3, 7, 32'hDEAD); set_rd(0, 3);
    chk_reads();
    chk_port0("x3_bypass", 32'hDEAD, 1'b1);
    tick();
    clear_inputs(); set_rd(0, 3);
    chk_reads();
    chk_port0("x3_committed", 32'hDEAD, 1'b1);
    tick();

    // Two writers to x4; the older commit must leave x4 busy with the younger tag.
    clear_inputs(); set_disp(4, 2); tick();
    clear_inputs(); set_disp(4, 5); tick();
    clear_inputs(); set_cmt(0, 4, 2, 32'h11); set_rd(0, 4);
    chk_reads();
    chk_port0("x4_stale_no_bypass", 32'd5, 1'b0);
    tick();
    clear_inputs(); set_rd(0, 4);
    chk_reads();
    chk_port0("x4_still_busy", 32'd5, 1'b0);
    tick();

    // Commit and re-dispatch of x6 in the same cycle.
    clear_inputs(); set_disp(6, 1); tick();
    clear_inputs(); set_cmt(0, 6, 1, 32'h66); set_disp(6, 9); tick();
    clear_inputs(); set_rd(0, 6);
    chk_reads();
    chk_port0("x6_redispatched", 32'd9, 1'b0);
    tick();

    // Both ports commit x8: youngest wins. Writes to x0 are ignored.
    clear_inputs(); set_cmt(0, 8, 0, 32'hA); set_cmt(1, 8, 0, 32'hB); set_rd(0, 8);
    chk_reads();
    chk_port0("x8_bypass_youngest", 32'hB, 1'b1);
    tick();
    clear_inputs(); set_rd(0, 8); set_disp(0, 3); set_cmt(0, 0, 0, 32'h99); set_rd(1, 0);
    chk_reads();
    chk_port0("x8_youngest", 32'hB, 1'b1);
    tick();
    clear_inputs(); set_rd(0, 0);
    chk_reads();
    chk_port0("x0_zero", '0, 1'b1);
    tick();

    // Flush with a same-cycle commit and a dropped dispatch.
    clear_inputs(); set_disp(2, 3); tick();
    clear_inputs(); set_disp(9, 4); tick();
    clear_inputs(); i_flush = 1'b1; set_cmt(0, 2, 3, 32'h55); set_disp(10, 6); tick();
    clear_inputs(); set_rd(0, 2); set_rd(1, 9);
    chk_reads();
    chk_port0("flush_x2", 32'h55, 1'b1);
    check_eq("flush_x9_rdy", 64'(o_rd_ready[1]), 64'd1);
    tick();
    clear_inputs(); set_rd(0, 10); set_rd(1, 4);
    chk_reads();
    check_eq("flush_x10_rdy", 64'(o_rd_ready[0]), 64'd1);
    check_eq("flush_x4_data", 64'(o_rd_val[2*XLEN-1:XLEN]), 64'h11);
    tick();
    clear_inputs(); set_rd(0, 6);
    chk_reads();
    chk_port0("flush_x6_data", 32'h66, 1'b1);
    tick();

    // Randomized traffic over a narrow register window to force collisions.
    for (int c = 0; c < 600; c++) begin
      clear_inputs();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) != 0) set_disp($urandom_range(0, 11), $urandom_range(0, 15));
      for (int k = 0; k < int'(NCMT); k++) begin
        if ($urandom_range(0, 1) != 0) begin
          rd = $urandom_range(0, 11);
          set_cmt(k, rd, ($urandom_range(0, 3) != 0) ? int'(m_tag[rd]) : $urandom_range(0, 15),
                  $urandom);
        end
      end
      i_flush = ($urandom_range(0, 24) == 0);
      for (int p = 0; p < int'(NRD); p++) set_rd(p, $urandom_range(0, 11));
      chk_reads();
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
